// File: rtl/stream_transpose_pkg.sv
// stream_transpose_pkg: shared widths, bank status type and bank count for the transpose engine.
package stream_transpose_pkg;
  localparam int NB = 2;
  typedef enum logic {EMPTY, FULL} bank_st_e;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/stream_transpose_if.sv
// stream_transpose_if: input and output valid/ready streams plus framing error of the transpose engine.
interface stream_transpose_if #(parameter int DATA_WIDTH = 8);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_tr;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  err;
  modport master (output s_valid, s_data, s_last, s_tr, m_ready,
                  input  s_ready, m_valid, m_data, m_last, err);
  modport slave  (input  s_valid, s_data, s_last, s_tr, m_ready,
                  output s_ready, m_valid, m_data, m_last, err);
endinterface

// File: rtl/stream_transpose_bank.sv
// transpose_bank: one matrix of storage, synchronous write port and combinational read port.
module transpose_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/stream_transpose.sv
// stream_transpose: ping-pong buffered M x N matrix transpose / pass-through on valid/ready streams.
module stream_transpose
  import stream_transpose_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  stream_transpose_if.slave io
);
  localparam int W = idx_w(M*N);
  typedef logic [W-1:0] cnt_t;
  typedef logic [W:0]   idx_t;
  localparam cnt_t M1 = cnt_t'(M-1);
  localparam cnt_t N1 = cnt_t'(N-1);
  cnt_t wr_r_q, wr_r_d, wr_c_q, wr_c_d, rd_r_q, rd_r_d, rd_c_q, rd_c_d;
  cnt_t wr_addr, rd_addr;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  bank_st_e full_q [NB];
  bank_st_e full_d [NB];
  logic [NB-1:0] mode_q, mode_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] rdata [NB];
  logic s_rdy, acc, wr_end, rd_end, load, rd_tr, adv_r, adv_c;
  assign s_rdy   = full_q[wr_bank_q] == EMPTY;
  assign acc     = io.s_valid && s_rdy;
  assign wr_end  = wr_r_q == M1 && wr_c_q == N1;
  assign rd_end  = rd_r_q == M1 && rd_c_q == N1;
  assign load    = full_q[rd_bank_q] == FULL && (!m_valid_q || io.m_ready);
  assign rd_tr   = mode_q[rd_bank_q];
  // transpose walks rows fastest, pass-through walks columns fastest; both end at (M-1,N-1)
  assign adv_r   = load && (rd_tr || rd_c_q == N1);
  assign adv_c   = load && (!rd_tr || rd_r_q == M1);
  assign wr_addr = cnt_t'(idx_t'(wr_r_q) * idx_t'(N) + idx_t'(wr_c_q));
  assign rd_addr = cnt_t'(idx_t'(rd_r_q) * idx_t'(N) + idx_t'(rd_c_q));
  for (genvar b = 0; b < NB; b++) begin : g_bank
    transpose_bank #(.DEPTH(M*N), .AW(W), .DW(DATA_WIDTH)) u_bank (
      .clk   (clk),
      .we    (acc && wr_bank_q == 1'(b)),
      .waddr (wr_addr),
      .wdata (io.s_data),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end
  always_comb begin
    wr_c_d    = !acc ? wr_c_q : wr_c_q == N1 ? '0 : wr_c_q + cnt_t'(1);
    wr_r_d    = (!acc || wr_c_q != N1) ? wr_r_q : wr_end ? '0 : wr_r_q + cnt_t'(1);
    wr_bank_d = wr_bank_q ^ (acc && wr_end);
    mode_d    = mode_q;
    if (acc && wr_r_q == '0 && wr_c_q == '0) mode_d[wr_bank_q] = io.s_tr;
    full_d    = full_q;
    if (acc && wr_end) full_d[wr_bank_q] = FULL;
    if (load && rd_end) full_d[rd_bank_q] = EMPTY;
    rd_r_d    = !adv_r ? rd_r_q : rd_r_q == M1 ? '0 : rd_r_q + cnt_t'(1);
    rd_c_d    = !adv_c ? rd_c_q : rd_c_q == N1 ? '0 : rd_c_q + cnt_t'(1);
    rd_bank_d = rd_bank_q ^ (load && rd_end);
    m_valid_d = load || (m_valid_q && !io.m_ready);
    m_data_d  = load ? rdata[rd_bank_q] : m_data_q;
    m_last_d  = load ? rd_end : m_last_q;
    err_d     = acc && (io.s_last != wr_end);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r_q    <= '0;
      wr_c_q    <= '0;
      rd_r_q    <= '0;
      rd_c_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '{default: EMPTY};
      mode_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_r_q    <= wr_r_d;
      wr_c_q    <= wr_c_d;
      rd_r_q    <= rd_r_d;
      rd_c_q    <= rd_c_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end
  assign io.s_ready = s_rdy;
  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign io.m_last  = m_last_q;
  assign io.err     = err_q;
endmodule

// File: doc/stream_transpose.md
# stream_transpose

Streaming, double-buffered matrix transpose engine. It accepts an M×N matrix one element per beat in row-major order on a valid/ready input stream, and emits it column-major on a valid/ready output stream. This produces the N×M transpose, or a row-major pass-through when the per-matrix mode bit requests it. Two ping-pong banks let one matrix fill while the previous one drains, so the block sustains one element per cycle. It sits between stream producers and consumers that need transposed tiles without a full-width combinational bus.

## Interface
- M, 16: rows of input matrix (≥2)
- N, 16: columns of input matrix (≥2)
- DATA_WIDTH, 8: bits per element
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  element, row-major order
- s_last  in  1  producer marks element M*N-1 of a matrix
- s_tr  in  1  mode, sampled on first beat of each matrix: 1 = transpose, 0 = pass-through
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer accepts
- m_data  out  DATA_WIDTH  output element
- m_last  out  1  high on the final element of a matrix
- err  out  1  one-cycle pulse on s_last framing mismatch

## Operation
- Reset values: s_ready=1, m_valid=0, m_data=0, m_last=0, err=0; both banks empty; wr_bank=rd_bank=0; all counters 0. Reset is asynchronous at any time. A partial matrix, or a matrix not yet drained, is discarded; there is no flush.
- Write side: s_ready = !full[wr_bank].
  - Each accepted beat writes bank[wr_bank][wr_r*N+wr_c].
  - wr_c increments and wraps at N-1, then wr_r increments.
  - s_tr is latched into mode[wr_bank] when (wr_r,wr_c)=(0,0).
  - On beat index M*N-1: full[wr_bank]<=1, wr_bank toggles, counters clear.
- Framing check: err pulses on the cycle after any accepted beat where s_last ≠ (index==M*N-1). Framing is governed solely by the counters; s_last never resynchronises them.
- Read side: the output register loads when full[rd_bank] && (!m_valid || m_ready).
  - Transpose mode: the read index is rd_r*N+rd_c. rd_r advances first (wraps at M-1), then rd_c. Order is column 0 rows 0..M-1, column 1 rows 0..M-1, and so on.
  - Pass-through mode: the read index is a linear 0..M*N-1.
  - m_last=1 is loaded with element M*N-1 of the output order. On that load: full[rd_bank]<=0, rd_bank toggles, read counters clear.
  - When no load occurs and m_ready is high, m_valid<=0.
- Set of full[wr_bank] and clear of full[rd_bank] in the same cycle both take effect. They always target different banks, because a bank being written is never full and a bank being read always is.
- Both banks full: s_ready=0 until the drain of rd_bank completes. m_valid held with m_ready=0 keeps m_data/m_last stable.

## Timing
- Latency: when the last input beat of a matrix is accepted on edge E, m_valid rises after edge E+1, provided the output register is free.
- Throughput: 1 element/cycle sustained with s_valid=m_ready=1 continuously. There are no bubbles between matrices on either side.
- s_ready depends only on registered state, with no combinational path from m_ready. m_valid, m_data and m_last are registered.
- Counter width W = $clog2(M*N). Index arithmetic is done in W+1 bits to avoid overflow at M*N.

## Structure
- Package stream_transpose_pkg:
  - index-width function (clog2 wrapper);
  - typedef for the two-state bank status (EMPTY/FULL);
  - constant for bank count = 2.
- Sub-module transpose_bank: M*N×DATA_WIDTH register array with one synchronous write port and one combinational read port, instantiated twice.
- Top level holds the write/read counters, the full[]/mode[] flags, the output register and the err logic.

## Test plan
- M=2,N=3, s_tr=1, inputs 1..6 with s_last on 6, m_ready=1 → outputs 1,4,2,5,3,6; m_last only on 6; first m_valid two edges after accepting 6; err never pulses.
- Same stimulus with s_tr=0 → 1,2,3,4,5,6 unchanged. Then back-to-back matrices with s_tr 1,0,1 → each matrix in its own latched mode.
- Continuous stream of 4 matrices with m_ready=1 → s_ready never drops after reset; outputs are contiguous with no gaps.
- m_ready=0 held → exactly 2 matrices (12 beats) accepted, then s_ready=0. m_data is stable at 1 while stalled. Release → all 12 elements drain in order.
- s_last asserted on beat 4 of a 6-beat matrix, and omitted on beat 6 → err pulses twice; output data order is unaffected.
- rst_n low mid-write and mid-drain → all outputs go to reset values immediately. The next matrix after release transposes correctly from index 0.
